// File: rtl/lab0_alu_bist.sv
// lab0_alu_bist: on-chip exhaustive stimulus/checker for the lab0_top AND/OR datapath.
// Optional build macro LAB0_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module lab0_alu_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             left_pushbutton,
  output logic             right_pushbutton,
  output logic [3:0]       A,
  output logic [3:0]       B,
  input  logic [3:0]       result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_op,
  output logic [3:0]       fail_a,
  output logic [3:0]       fail_b,
  output logic [3:0]       fail_result
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [8:0]       LAST_INDEX  = 9'd511;
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

  // Reference behaviour of lab0_top: op 0 is AND, op 1 is OR.
  function automatic logic [3:0] golden_result(input logic op, input logic [3:0] a, input logic [3:0] b);
    if (op) begin
      golden_result = a | b;
    end else begin
      golden_result = a & b;
    end
  endfunction

  state_t           state_r, state_s;
  logic [8:0]       index_r, index_s;
  logic [3:0]       settle_cnt_r, settle_cnt_s;
  logic             left_r, left_s;
  logic             right_r, right_s;
  logic [3:0]       a_r, a_s;
  logic [3:0]       b_r, b_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic [ERR_W-1:0] err_count_r, err_count_s;
  logic             fail_seen_r, fail_seen_s;
  logic             fail_op_r, fail_op_s;
  logic [3:0]       fail_a_r, fail_a_s;
  logic [3:0]       fail_b_r, fail_b_s;
  logic [3:0]       fail_result_r, fail_result_s;
  logic             mismatch_s;
  logic             stop_s;
  logic             begin_sweep_s;

  // The op currently driven is carried by the right button (one-hot during a sweep).
  assign mismatch_s = (result != golden_result(right_r, a_r, b_r));

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_s       = state_r;
    index_s       = index_r;
    settle_cnt_s  = settle_cnt_r;
    left_s        = left_r;
    right_s       = right_r;
    a_s           = a_r;
    b_s           = b_r;
    busy_s        = busy_r;
    done_s        = done_r;
    pass_s        = pass_r;
    err_count_s   = err_count_r;
    fail_seen_s   = fail_seen_r;
    fail_op_s     = fail_op_r;
    fail_a_s      = fail_a_r;
    fail_b_s      = fail_b_r;
    fail_result_s = fail_result_r;
    stop_s        = 1'b0;
    begin_sweep_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        left_s  = 1'b0;
        right_s = 1'b0;
        a_s     = 4'h0;
        b_s     = 4'h0;
        busy_s  = 1'b0;
        if (start) begin
          begin_sweep_s = 1'b1;
        end else begin
          begin_sweep_s = 1'b0;
        end
      end

      ST_DRIVE: begin
        left_s       = ~index_r[8];
        right_s      = index_r[8];
        a_s          = index_r[7:4];
        b_s          = index_r[3:0];
        settle_cnt_s = SETTLE_LOAD;
        state_s      = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt_r == 4'd0) begin
          state_s = ST_CHECK;
        end else begin
          settle_cnt_s = settle_cnt_r - 4'd1;
        end
      end

      ST_CHECK: begin
        if (mismatch_s) begin
          if (err_count_r != ERR_MAX) begin
            err_count_s = err_count_r + ERR_ONE;
          end else begin
            err_count_s = err_count_r;
          end
          // A separate flag, not the captured values, marks the first failure.
          if (!fail_seen_r) begin
            fail_seen_s   = 1'b1;
            fail_op_s     = right_r;
            fail_a_s      = a_r;
            fail_b_s      = b_r;
            fail_result_s = result;
          end else begin
            fail_seen_s   = fail_seen_r;
          end
        end else begin
          err_count_s = err_count_r;
        end
`ifdef LAB0_BIST_STOP_ON_FAIL_EN
        stop_s = mismatch_s;
`else
        stop_s = 1'b0;
`endif
        if ((index_r == LAST_INDEX) || stop_s) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_count_s == ERR_ZERO);
          left_s  = 1'b0;
          right_s = 1'b0;
          a_s     = 4'h0;
          b_s     = 4'h0;
        end else begin
          index_s = index_r + 9'd1;
          state_s = ST_DRIVE;
        end
      end

      ST_DONE: begin
        if (start) begin
          begin_sweep_s = 1'b1;
        end else begin
          begin_sweep_s = 1'b0;
        end
      end

      default: begin
        state_s = ST_IDLE;
        left_s  = 1'b0;
        right_s = 1'b0;
        a_s     = 4'h0;
        b_s     = 4'h0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase

    if (begin_sweep_s) begin
      state_s       = ST_DRIVE;
      index_s       = 9'd0;
      err_count_s   = ERR_ZERO;
      fail_seen_s   = 1'b0;
      fail_op_s     = 1'b0;
      fail_a_s      = 4'h0;
      fail_b_s      = 4'h0;
      fail_result_s = 4'h0;
      done_s        = 1'b0;
      pass_s        = 1'b0;
      busy_s        = 1'b1;
    end else begin
      busy_s        = busy_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      index_r       <= 9'd0;
      settle_cnt_r  <= 4'd0;
      left_r        <= 1'b0;
      right_r       <= 1'b0;
      a_r           <= 4'h0;
      b_r           <= 4'h0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      err_count_r   <= ERR_ZERO;
      fail_seen_r   <= 1'b0;
      fail_op_r     <= 1'b0;
      fail_a_r      <= 4'h0;
      fail_b_r      <= 4'h0;
      fail_result_r <= 4'h0;
    end else begin
      state_r       <= state_s;
      index_r       <= index_s;
      settle_cnt_r  <= settle_cnt_s;
      left_r        <= left_s;
      right_r       <= right_s;
      a_r           <= a_s;
      b_r           <= b_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      pass_r        <= pass_s;
      err_count_r   <= err_count_s;
      fail_seen_r   <= fail_seen_s;
      fail_op_r     <= fail_op_s;
      fail_a_r      <= fail_a_s;
      fail_b_r      <= fail_b_s;
      fail_result_r <= fail_result_s;
    end
  end

  assign left_pushbutton  = left_r;
  assign right_pushbutton = right_r;
  assign A                = a_r;
  assign B                = b_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_count_r;
  assign fail_op          = fail_op_r;
  assign fail_a           = fail_a_r;
  assign fail_b           = fail_b_r;
  assign fail_result      = fail_result_r;

endmodule

// File: tb/tb_lab0_alu_bist.sv
// tb_lab0_alu_bist: scoreboard bench for lab0_alu_bist driving a behavioural lab0_top with selectable faults.
// Honours LAB0_BIST_STOP_ON_FAIL_EN when the design is built with it.
module tb_lab0_alu_bist;
  localparam int S  = 2;
  localparam int EW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          lp, rp;
  logic [3:0]    a, b, result;
  logic          busy, done, pass;
  logic [EW-1:0] err_count;
  logic          fail_op;
  logic [3:0]    fail_a, fail_b, fail_result;

  int total = 0;
  int bad   = 0;
  int fault_mode = 0;
  int lat;

  // scoreboard state: expected vector order plus expected summary results
  logic [9:0] exp_q[$];
  logic [9:0] prev_vec;
  int         sb_err, sb_vec, sb_first_idx;
  bit         sb_seen, sb_stopped;
  logic       sb_fop;
  logic [3:0] sb_fa, sb_fb, sb_fr;

  always #5 clk = ~clk;

  lab0_alu_bist #(.SETTLE_CYCLES(S), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .left_pushbutton(lp), .right_pushbutton(rp), .A(a), .B(b), .result(result),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_op(fail_op), .fail_a(fail_a), .fail_b(fail_b), .fail_result(fail_result)
  );

  function automatic logic [3:0] gold(input logic op, input logic [3:0] x, input logic [3:0] y);
    return op ? (x | y) : (x & y);
  endfunction

  // lab0_top stand-in: 0 correct, 1 result[0] stuck at 0, 2 OR computes XOR
  function automatic logic [3:0] model_out(input logic op, input logic [3:0] x, input logic [3:0] y, input int fm);
    logic [3:0] r;
    r = op ? ((fm == 2) ? (x ^ y) : (x | y)) : (x & y);
    if (fm == 1) r[0] = 1'b0;
    return r;
  endfunction

  always_comb begin
    result = 4'h0;
    if (lp || rp) result = model_out(rp, a, b, fault_mode);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // monitor: each new vector the DUT drives is matched against the queue and scored
  always @(negedge clk) begin
    logic [9:0] cur;
    logic [9:0] e;
    logic [3:0] r;
    cur = {lp, rp, a, b};
    if (rst || !(lp || rp)) begin
      prev_vec = 10'h0;
    end else if (cur != prev_vec) begin
      prev_vec = cur;
      if (exp_q.size() == 0) begin
        check_eq("vec_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("vector", 32'(cur), 32'(e));
        r = model_out(rp, a, b, fault_mode);
        if (!sb_stopped && r != gold(rp, a, b)) begin
          if (!sb_seen) begin
            sb_seen = 1'b1; sb_first_idx = sb_vec;
            sb_fop = rp; sb_fa = a; sb_fb = b; sb_fr = r;
`ifdef LAB0_BIST_STOP_ON_FAIL_EN
            sb_stopped = 1'b1;
`endif
          end
          sb_err++;
        end
        sb_vec++;
      end
    end
  end

  task automatic sb_clear();
    exp_q.delete();
    sb_err = 0; sb_vec = 0; sb_first_idx = 0; sb_seen = 1'b0; sb_stopped = 1'b0;
    sb_fop = 1'b0; sb_fa = 4'h0; sb_fb = 4'h0; sb_fr = 4'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_drives"}, 32'({lp, rp, a, b}), 32'd0);
    check_eq({tag, "_flags"}, 32'({busy, done, pass}), 32'd0);
    check_eq({tag, "_err"}, 32'(err_count), 32'd0);
    check_eq({tag, "_fail"}, 32'({fail_op, fail_a, fail_b, fail_result}), 32'd0);
  endtask

  // pushes the expected 512-vector order, then pulses start for exactly one edge (edge k)
  task automatic start_sweep();
    @(negedge clk);
    sb_clear();
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      exp_q.push_back({~v[8], v[8], v[7:4], v[3:0]});
    end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("done_cleared", 32'(done), 32'd0);
    check_eq("err_cleared", 32'(err_count), 32'd0);
  endtask

  // lat is the edge index (relative to k) at which done is first sampled high
  task automatic wait_done(input int inj, output int lat_o);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (inj > 0 && n == inj) start = 1'b1;
      if (inj > 0 && n == inj + 1) start = 1'b0;
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);
    lat_o = n + 1;
  endtask

  task automatic check_results(input int lat_i);
    int nvec;
    nvec = sb_stopped ? (sb_first_idx + 1) : 512;
    check_eq("done_latency", 32'(lat_i), 32'(nvec * (S + 2) + 1));
    check_eq("busy_low", 32'(busy), 32'd0);
    check_eq("pass", 32'(pass), 32'(sb_err == 0));
    check_eq("err_count", 32'(err_count), 32'(sb_err));
    check_eq("fail_op", 32'(fail_op), 32'(sb_fop));
    check_eq("fail_a", 32'(fail_a), 32'(sb_fa));
    check_eq("fail_b", 32'(fail_b), 32'(sb_fb));
    check_eq("fail_result", 32'(fail_result), 32'(sb_fr));
    check_eq("drives_after_done", 32'({lp, rp, a, b}), 32'd0);
`ifndef LAB0_BIST_STOP_ON_FAIL_EN
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sb_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // clean model
    fault_mode = 0;
    start_sweep();
    wait_done(0, lat);
    check_results(lat);
    check_eq("clean_latency", 32'(lat), 32'd2049);
    check_eq("clean_pass", 32'(pass), 32'd1);

    // start during a sweep must be ignored
    start_sweep();
    wait_done(100, lat);
    check_results(lat);
    check_eq("ignored_start_latency", 32'(lat), 32'd2049);

    // result[0] stuck at 0: 64 AND + 192 OR mismatches, first at AND/1/1
    fault_mode = 1;
    start_sweep();
    wait_done(0, lat);
    check_results(lat);
    check_eq("stuck_first", 32'({fail_op, fail_a, fail_b, fail_result}), 32'({1'b0, 4'h1, 4'h1, 4'h0}));
`ifdef LAB0_BIST_STOP_ON_FAIL_EN
    check_eq("stuck_err_stop", 32'(err_count), 32'd1);
    check_eq("stuck_latency_stop", 32'(lat), 32'd73);
`else
    check_eq("stuck_err", 32'(err_count), 32'd256);
`endif

    // OR returns A^B: differs from A|B exactly where A&B!=0, i.e. 256-3^4 = 175 vectors
    fault_mode = 2;
    start_sweep();
    wait_done(0, lat);
    check_results(lat);
    check_eq("xor_first", 32'({fail_op, fail_a, fail_b, fail_result}), 32'({1'b1, 4'h1, 4'h1, 4'h0}));
`ifdef LAB0_BIST_STOP_ON_FAIL_EN
    check_eq("xor_err_stop", 32'(err_count), 32'd1);
`else
    check_eq("xor_err", 32'(err_count), 32'd175);
`endif

    // reset mid-sweep, with start held alongside rst, then a clean sweep
    fault_mode = 0;
    start_sweep();
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_reset_outputs("mid_reset");
    sb_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("idle_after_reset", 32'({busy, done}), 32'd0);
    start_sweep();
    wait_done(0, lat);
    check_results(lat);
    check_eq("post_reset_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
